// File: rtl/alu_unit.sv
// Integer execution unit: one RV32I ALU/branch/jump op per cycle,
// registered onto the result broadcast bus with one cycle of latency.
module alu_unit #(
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_en,
  input  logic [6:0]           alu_opcode,
  input  logic [2:0]           alu_func3,
  input  logic                 alu_func1,
  input  logic [DATA_W-1:0]    alu_val1,
  input  logic [DATA_W-1:0]    alu_val2,
  input  logic [DATA_W-1:0]    alu_imm,
  input  logic [DATA_W-1:0]    alu_pc,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  output logic                 result_en,
  output logic [ROB_POS_W-1:0] result_rob_pos,
  output logic [DATA_W-1:0]    result_val,
  output logic                 result_jump,
  output logic [DATA_W-1:0]    result_pc
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPI    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic                 en_q, en_d;
  logic [ROB_POS_W-1:0] rob_q, rob_d;
  logic [DATA_W-1:0]    val_q, val_d;
  logic                 jump_q, jump_d;
  logic [DATA_W-1:0]    pc_q, pc_d;

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] pc_4;
  logic [DATA_W-1:0] jalr_tgt;
  logic [4:0]        shamt;
  logic              cond;
  logic              is_op, is_opi, is_lui, is_auipc;
  logic              is_jal, is_jalr, is_br;

  assign is_op    = (alu_opcode == OPC_OP);
  assign is_opi   = (alu_opcode == OPC_OPI);
  assign is_lui   = (alu_opcode == OPC_LUI);
  assign is_auipc = (alu_opcode == OPC_AUIPC);
  assign is_jal   = (alu_opcode == OPC_JAL);
  assign is_jalr  = (alu_opcode == OPC_JALR);
  assign is_br    = (alu_opcode == OPC_BRANCH);

  assign op_b     = is_op ? alu_val2 : alu_imm;
  assign shamt    = op_b[4:0];
  assign pc_4     = alu_pc + DATA_W'(4);
  assign jalr_tgt = (alu_val1 + alu_imm) & ~DATA_W'(1);

  always_comb begin
    alu_res = '0;
    unique case (alu_func3)
      3'b000: alu_res = (is_op && alu_func1) ? alu_val1 - op_b
                                             : alu_val1 + op_b;
      3'b001: alu_res = alu_val1 << shamt;
      3'b010: alu_res = DATA_W'($signed(alu_val1) < $signed(op_b));
      3'b011: alu_res = DATA_W'(alu_val1 < op_b);
      3'b100: alu_res = alu_val1 ^ op_b;
      3'b101: alu_res = alu_func1 ? DATA_W'($signed(alu_val1) >>> shamt)
                                  : alu_val1 >> shamt;
      3'b110: alu_res = alu_val1 | op_b;
      3'b111: alu_res = alu_val1 & op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    unique case (alu_func3)
      3'b000:  cond = (alu_val1 == alu_val2);
      3'b001:  cond = (alu_val1 != alu_val2);
      3'b100:  cond = ($signed(alu_val1) < $signed(alu_val2));
      3'b101:  cond = ($signed(alu_val1) >= $signed(alu_val2));
      3'b110:  cond = (alu_val1 < alu_val2);
      3'b111:  cond = (alu_val1 >= alu_val2);
      default: cond = 1'b0;
    endcase
  end

  // rollback outranks rdy; rdy low freezes every output register
  always_comb begin
    en_d   = en_q;
    rob_d  = rob_q;
    val_d  = val_q;
    jump_d = jump_q;
    pc_d   = pc_q;
    if (rollback) begin
      en_d = 1'b0;
    end else if (rdy) begin
      en_d = alu_en;
      if (alu_en) begin
        rob_d  = alu_rob_pos;
        val_d  = '0;
        jump_d = 1'b0;
        pc_d   = pc_4;
        unique case (1'b1)
          is_op, is_opi: val_d = alu_res;
          is_lui:        val_d = alu_imm;
          is_auipc:      val_d = alu_pc + alu_imm;
          is_jal: begin
            val_d  = pc_4;
            jump_d = 1'b1;
            pc_d   = alu_pc + alu_imm;
          end
          is_jalr: begin
            val_d  = pc_4;
            jump_d = 1'b1;
            pc_d   = jalr_tgt;
          end
          is_br: begin
            jump_d = cond;
            pc_d   = cond ? alu_pc + alu_imm : pc_4;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      rob_q  <= '0;
      val_q  <= '0;
      jump_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      en_q   <= en_d;
      rob_q  <= rob_d;
      val_q  <= val_d;
      jump_q <= jump_d;
      pc_q   <= pc_d;
    end
  end

  assign result_en      = en_q;
  assign result_rob_pos = rob_q;
  assign result_val     = val_q;
  assign result_jump    = jump_q;
  assign result_pc      = pc_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: behavioural model checked every cycle,
// plus directed vectors with hand-computed literals.
module tb_alu_unit;

  localparam logic [6:0] OP  = 7'h33;
  localparam logic [6:0] OPI = 7'h13;
  localparam logic [6:0] LUI = 7'h37;
  localparam logic [6:0] AUI = 7'h17;
  localparam logic [6:0] JAL = 7'h6f;
  localparam logic [6:0] JLR = 7'h67;
  localparam logic [6:0] BR  = 7'h63;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, alu_en, alu_func1;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        result_en, result_jump;
  logic [3:0]  result_rob_pos;
  logic [31:0] result_val, result_pc;

  int checks = 0;
  int failures = 0;

  alu_unit #(.DATA_W(32), .ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_func3(alu_func3), .alu_func1(alu_func1),
    .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos),
    .result_en(result_en), .result_rob_pos(result_rob_pos),
    .result_val(result_val), .result_jump(result_jump),
    .result_pc(result_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(
    input logic [6:0] opc, input logic [2:0] f3, input logic f1,
    input logic [31:0] v1, input logic [31:0] v2,
    input logic [31:0] imm, input logic [31:0] pc,
    output logic [31:0] v, output logic j, output logic [31:0] np);
    longint sa, sb, sv2, ua, ub, uv2;
    logic [31:0] b;
    int sh;
    logic c;
    b   = (opc == OP) ? v2 : imm;
    sh  = int'(b % 32);
    sa  = longint'($signed(v1));
    sb  = longint'($signed(b));
    sv2 = longint'($signed(v2));
    ua  = longint'(v1);
    ub  = longint'(b);
    uv2 = longint'(v2);
    v = 32'd0; j = 1'b0; np = pc + 32'd4;
    c = 1'b0;
    case (opc)
      OP, OPI: begin
        case (f3)
          3'd0: v = (opc == OP && f1) ? 32'(ua - ub) : 32'(ua + ub);
          3'd1: v = 32'(ua * (64'd1 << sh));
          3'd2: v = (sa < sb) ? 32'd1 : 32'd0;
          3'd3: v = (ua < ub) ? 32'd1 : 32'd0;
          3'd4: v = v1 ^ b;
          3'd5: v = f1 ? 32'(sa >>> sh) : 32'(ua / (64'd1 << sh));
          3'd6: v = v1 | b;
          default: v = v1 & b;
        endcase
      end
      LUI: v = imm;
      AUI: v = pc + imm;
      JAL: begin v = pc + 32'd4; j = 1'b1; np = pc + imm; end
      JLR: begin
        v = pc + 32'd4; j = 1'b1;
        np = 32'((ua + longint'(imm)) / 2 * 2);
      end
      BR: begin
        case (f3)
          3'd0: c = (v1 == v2);
          3'd1: c = (v1 != v2);
          3'd4: c = (sa < sv2);
          3'd5: c = (sa >= sv2);
          3'd6: c = (ua < uv2);
          3'd7: c = (ua >= uv2);
          default: c = 1'b0;
        endcase
        j = c;
        np = c ? pc + imm : pc + 32'd4;
      end
      default: ;
    endcase
  endfunction

  logic        exp_en = 1'b0, exp_j = 1'b0, started = 1'b0;
  logic [3:0]  exp_rob = '0;
  logic [31:0] exp_val = '0, exp_pc = '0;

  always @(posedge clk) begin
    logic [31:0] mv, mp;
    logic mj;
    started <= 1'b1;
    if (rst) begin
      exp_en = 0; exp_j = 0; exp_rob = 0; exp_val = 0; exp_pc = 0;
    end else if (rollback) begin
      exp_en = 0;
    end else if (rdy) begin
      exp_en = alu_en;
      if (alu_en) begin
        model(alu_opcode, alu_func3, alu_func1, alu_val1, alu_val2,
              alu_imm, alu_pc, mv, mj, mp);
        exp_rob = alu_rob_pos; exp_val = mv; exp_j = mj; exp_pc = mp;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_en", 32'(result_en), 32'(exp_en));
      if (exp_en) begin
        chk("m_rob", 32'(result_rob_pos), 32'(exp_rob));
        chk("m_val", result_val, exp_val);
        chk("m_jump", 32'(result_jump), 32'(exp_j));
        chk("m_pc", result_pc, exp_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                       input logic f1, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] rob);
    alu_en = 1'b1; alu_opcode = opc; alu_func3 = f3; alu_func1 = f1;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc;
    alu_rob_pos = rob;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
    alu_opcode = '0; alu_func3 = '0; alu_func1 = 1'b0;
    alu_val1 = '0; alu_val2 = '0; alu_imm = '0; alu_pc = '0;
    alu_rob_pos = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_en", 32'(result_en), 32'd0);
    chk("rst_jump", 32'(result_jump), 32'd0);
    chk("rst_rob", 32'(result_rob_pos), 32'd0);
    chk("rst_val", result_val, 32'd0);
    chk("rst_pc", result_pc, 32'd0);

    issue(OP, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'h10, 4'd3);
    step();
    chk("sub_en", 32'(result_en), 32'd1);
    chk("sub_rob", 32'(result_rob_pos), 32'd3);
    chk("sub_val", result_val, 32'hFFFF_FFFE);

    issue(OPI, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h14, 4'd4);
    step();
    chk("srai_val", result_val, 32'hF800_0000);
    issue(OPI, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'h18, 4'd5);
    step();
    chk("srli_val", result_val, 32'h0800_0000);

    issue(BR, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
    step();
    chk("blt_jump", 32'(result_jump), 32'd1);
    chk("blt_pc", result_pc, 32'h120);
    chk("blt_val", result_val, 32'd0);
    issue(BR, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd7);
    step();
    chk("bltu_jump", 32'(result_jump), 32'd0);
    chk("bltu_pc", result_pc, 32'h104);

    issue(JLR, 3'd0, 1'b0, 32'h1001, 32'd0, 32'd2, 32'h40, 4'd8);
    step();
    chk("jalr_val", result_val, 32'h44);
    chk("jalr_jump", 32'(result_jump), 32'd1);
    chk("jalr_pc", result_pc, 32'h1002);

    issue(OPI, 3'd0, 1'b1, 32'd5, 32'd0, 32'd7, 32'h50, 4'd9);
    step();
    chk("addi_f1_val", result_val, 32'd12);
    issue(7'h7F, 3'd0, 1'b0, 32'd9, 32'd9, 32'd9, 32'h60, 4'd10);
    step();
    chk("unk_en", 32'(result_en), 32'd1);
    chk("unk_val", result_val, 32'd0);
    chk("unk_pc", result_pc, 32'h64);

    // back-to-back directed mix, checked by the model each cycle
    issue(LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h70, 4'd1); step();
    issue(AUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'h0000_1000, 32'h74, 4'd2); step();
    issue(JAL, 3'd0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h78, 4'd3); step();
    chk("jal_pc", result_pc, 32'h68);
    issue(BR, 3'd0, 1'b0, 32'd7, 32'd7, 32'h40, 32'h80, 4'd4); step();
    issue(BR, 3'd1, 1'b0, 32'd7, 32'd7, 32'h40, 32'h84, 4'd5); step();
    issue(BR, 3'd5, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h88, 4'd6); step();
    issue(BR, 3'd7, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h8C, 4'd7); step();
    issue(BR, 3'd2, 1'b0, 32'd1, 32'd1, 32'h8, 32'h90, 4'd8); step();
    issue(OP, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h94, 4'd9); step();
    chk("slt_val", result_val, 32'd1);
    issue(OP, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h98, 4'd10); step();
    issue(OP, 3'd1, 1'b0, 32'h0000_0003, 32'd33, 32'd0, 32'h9C, 4'd11); step();
    chk("sll_val", result_val, 32'd6);
    issue(OP, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hA0, 4'd12); step();
    issue(OP, 3'd6, 1'b0, 32'hF0F0_F0F0, 32'h0F00_000F, 32'd0, 32'hA4, 4'd13); step();
    issue(OPI, 3'd7, 1'b0, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FF0F, 32'hA8, 4'd14); step();
    issue(OP, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hAC, 4'd15); step();
    chk("add_wrap", result_val, 32'd1);
    alu_en = 1'b0; step();
    chk("idle_en", 32'(result_en), 32'd0);

    // rollback on the edge that samples B
    issue(OP, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'hB0, 4'd1); step();
    chk("rbA_en", 32'(result_en), 32'd1);
    chk("rbA_rob", 32'(result_rob_pos), 32'd1);
    issue(OP, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0, 32'hB4, 4'd2);
    rollback = 1'b1; step();
    chk("rbB_en", 32'(result_en), 32'd0);
    rollback = 1'b0; alu_en = 1'b0; step();
    chk("rb_after_en", 32'(result_en), 32'd0);

    // rdy low freezes outputs
    issue(OP, 3'd0, 1'b0, 32'd10, 32'd20, 32'd0, 32'hC0, 4'd5); step();
    issue(OP, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'hC4, 4'd6);
    rdy = 1'b0; step(); step();
    chk("frz_en", 32'(result_en), 32'd1);
    chk("frz_val", result_val, 32'd30);
    chk("frz_rob", 32'(result_rob_pos), 32'd5);
    rdy = 1'b1; alu_en = 1'b0; step();
    chk("unfrz_en", 32'(result_en), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
